// File: rtl/byte_ram_responder.sv
// Byte-wide RAM responder for the memory-access stage: synchronous byte RAM
// with a memory-mapped TX FIFO and status register.
module byte_ram_responder #(
    parameter int          ADDR_WIDTH   = 17,
    parameter logic [31:0] IO_TX_ADDR   = 32'h0003_0000,
    parameter logic [31:0] IO_STAT_ADDR = 32'h0003_0004,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        re_i,
    input  logic [31:0] raddr_i,
    output logic [7:0]  rdata_o,
    input  logic        we_i,
    input  logic [31:0] waddr_i,
    input  logic [7:0]  wdata_i,
    output logic        io_valid_o,
    output logic [7:0]  io_data_o,
    input  logic        io_ready_i,
    output logic        ovf_o
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [7:0] mem [2**ADDR_WIDTH];
    logic [7:0] fifo [FIFO_DEPTH];

    logic [PW:0] wp;
    logic [PW:0] rp;
    logic        ovf;

    logic [ADDR_WIDTH-1:0] ridx;
    logic [ADDR_WIDTH-1:0] widx;

    logic       empty;
    logic       full;
    logic       pop;
    logic       tx_wr;
    logic       push;
    logic       drop;
    logic       stat_rd;
    logic       tx_rd;
    logic       ram_rd;
    logic       ram_wr;
    logic       fwd;
    logic [7:0] status;
    logic [7:0] rd_next;

    assign ridx = raddr_i[ADDR_WIDTH-1:0];
    assign widx = waddr_i[ADDR_WIDTH-1:0];

    // Extra wrap bit on the pointers distinguishes full from empty.
    assign empty = (wp == rp);
    assign full  = (wp[PW] != rp[PW]) &&
                   (wp[PW-1:0] == rp[PW-1:0]);

    assign pop   = ~empty & io_ready_i;
    assign tx_wr = we_i && (waddr_i == IO_TX_ADDR);
    assign push  = tx_wr && (~full || pop);
    assign drop  = tx_wr && ~push;

    assign stat_rd = re_i && (raddr_i == IO_STAT_ADDR);
    assign tx_rd   = re_i && (raddr_i == IO_TX_ADDR);
    assign ram_rd  = re_i && ~stat_rd && ~tx_rd;

    assign ram_wr = we_i &&
                    (waddr_i != IO_TX_ADDR) &&
                    (waddr_i != IO_STAT_ADDR);

    // Aliased addresses hit the same byte, so compare the RAM index only.
    assign fwd = ram_wr && (widx == ridx);

    assign status = {5'b0, ovf, full, empty};

    always_comb begin
        rd_next = rdata_o;
        unique case (1'b1)
            stat_rd:         rd_next = status;
            tx_rd:           rd_next = 8'h00;
            ram_rd && fwd:   rd_next = wdata_i;
            ram_rd && !fwd:  rd_next = mem[ridx];
            default:         ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ram_wr) begin
            mem[widx] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wp[PW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_o <= 8'h00;
            wp      <= '0;
            rp      <= '0;
            ovf     <= 1'b0;
        end else begin
            rdata_o <= rd_next;
            wp      <= wp + (PW+1)'(push);
            rp      <= rp + (PW+1)'(pop);
            // A drop on the clearing status read keeps the flag set.
            ovf     <= drop | (ovf & ~stat_rd);
        end
    end

    assign io_valid_o = ~empty;
    assign io_data_o  = empty ? 8'h00 : fifo[rp[PW-1:0]];
    assign ovf_o      = ovf;

endmodule

// File: tb/tb_byte_ram_responder.sv
// Scoreboard bench for byte_ram_responder: RAM reads, aliasing,
// write-first, TX FIFO overflow, drain, push/pop on full, async reset.
module tb_byte_ram_responder;

    localparam logic [31:0] TX   = 32'h0003_0000;
    localparam logic [31:0] STAT = 32'h0003_0004;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        re_i = 1'b0;
    logic [31:0] raddr_i = '0;
    logic [7:0]  rdata_o;
    logic        we_i = 1'b0;
    logic [31:0] waddr_i = '0;
    logic [7:0]  wdata_i = '0;
    logic        io_valid_o;
    logic [7:0]  io_data_o;
    logic        io_ready_i = 1'b0;
    logic        ovf_o;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] rd_q[$];
    logic [7:0] tx_q[$];
    logic       ovf_m = 1'b0;

    byte_ram_responder dut (
        .clk        (clk),
        .rst        (rst),
        .re_i       (re_i),
        .raddr_i    (raddr_i),
        .rdata_o    (rdata_o),
        .we_i       (we_i),
        .waddr_i    (waddr_i),
        .wdata_i    (wdata_i),
        .io_valid_o (io_valid_o),
        .io_data_o  (io_data_o),
        .io_ready_i (io_ready_i),
        .ovf_o      (ovf_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] stat_model();
        return {5'b0, ovf_m, tx_q.size() == DEPTH, tx_q.size() == 0};
    endfunction

    task automatic ram_write(input logic [31:0] a, input logic [7:0] d);
        we_i = 1'b1; waddr_i = a; wdata_i = d;
        tick();
        we_i = 1'b0;
    endtask

    // Drives one read and queues its expected data; caller compares.
    task automatic issue_read(input logic [31:0] a, input logic [7:0] e);
        re_i = 1'b1; raddr_i = a;
        rd_q.push_back(e);
        if (a == STAT) ovf_m = 1'b0;
        tick();
        re_i = 1'b0;
    endtask

    // TX write with io_ready_i low; the model decides accept/drop.
    task automatic tx_write(input logic [7:0] d);
        if (tx_q.size() < DEPTH) tx_q.push_back(d);
        else ovf_m = 1'b1;
        ram_write(TX, d);
    endtask

    task automatic test_reset();
        logic [7:0] e;
        n_checks++;
        if (rdata_o !== 8'h00 || io_valid_o !== 1'b0 ||
            io_data_o !== 8'h00 || ovf_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: rdata=%h valid=%b data=%h ovf=%b",
                     rdata_o, io_valid_o, io_data_o, ovf_o);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        ram_write(32'h10, 8'hA5);
        issue_read(32'h10, 8'hA5);
        e = rd_q.pop_front();
        n_checks++;
        if (rdata_o !== e) begin
            n_fail++;
            $display("FAIL ram_rw: got %h want %h", rdata_o, e);
        end
        n_checks++;
        if (io_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ram_no_tx: valid %b want 0", io_valid_o);
        end
    endtask

    task automatic test_stream_alias();
        logic [7:0]  vals [4];
        logic [31:0] addrs [5];
        logic [7:0]  e;
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        addrs = '{32'h20, 32'h21, 32'h22, 32'h23, 32'h0002_0020};
        for (int i = 0; i < 4; i++) ram_write(32'h20 + i, vals[i]);
        for (int i = 0; i < 5; i++) begin
            re_i = 1'b1; raddr_i = addrs[i];
            rd_q.push_back(vals[i % 4]);
            tick();
            e = rd_q.pop_front();
            n_checks++;
            if (rdata_o !== e) begin
                n_fail++;
                $display("FAIL stream[%0d] addr %h: got %h want %h",
                         i, addrs[i], rdata_o, e);
            end
        end
        re_i = 1'b0;
        raddr_i = 32'h23;
        tick();
        n_checks++;
        if (rdata_o !== 8'h11) begin
            n_fail++;
            $display("FAIL read_hold: got %h want 11", rdata_o);
        end
    endtask

    task automatic test_write_first();
        logic [7:0] e;
        we_i = 1'b1; waddr_i = 32'h40; wdata_i = 8'h5A;
        re_i = 1'b1; raddr_i = 32'h40;
        rd_q.push_back(8'h5A);
        tick();
        we_i = 1'b0; re_i = 1'b0;
        e = rd_q.pop_front();
        n_checks++;
        if (rdata_o !== e) begin
            n_fail++;
            $display("FAIL write_first: got %h want %h", rdata_o, e);
        end
        ram_write(STAT, 8'hFF);
        issue_read(TX, 8'h00);
        e = rd_q.pop_front();
        n_checks++;
        if (rdata_o !== e) begin
            n_fail++;
            $display("FAIL tx_addr_read: got %h want %h", rdata_o, e);
        end
    endtask

    task automatic test_tx_overflow();
        logic [7:0] e;
        io_ready_i = 1'b0;
        for (int i = 1; i <= 9; i++) tx_write(8'(i));
        n_checks++;
        if (ovf_o !== 1'b1 || io_valid_o !== 1'b1 || io_data_o !== 8'h01) begin
            n_fail++;
            $display("FAIL tx_ovf: ovf=%b valid=%b data=%h want 1 1 01",
                     ovf_o, io_valid_o, io_data_o);
        end
        for (int i = 0; i < 2; i++) begin
            issue_read(STAT, stat_model());
            e = rd_q.pop_front();
            n_checks++;
            if (rdata_o !== e) begin
                n_fail++;
                $display("FAIL status_read[%0d]: got %h want %h",
                         i, rdata_o, e);
            end
        end
    endtask

    task automatic test_drain();
        int k;
        logic [7:0] e;
        k = 0;
        io_ready_i = 1'b1;
        while (io_valid_o === 1'b1 && k < 20) begin
            n_checks++;
            if (tx_q.size() == 0) begin
                n_fail++;
                $display("FAIL drain_extra: got %h want no data", io_data_o);
            end else if (io_data_o !== tx_q[0]) begin
                n_fail++;
                $display("FAIL drain[%0d]: got %h want %h",
                         k, io_data_o, tx_q[0]);
            end
            tick();
            if (tx_q.size() != 0) void'(tx_q.pop_front());
            k++;
        end
        n_checks++;
        if (k != 8 || tx_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_count: got %0d want 8", k);
        end
        tick();
        io_ready_i = 1'b0;
        issue_read(STAT, stat_model());
        e = rd_q.pop_front();
        n_checks++;
        if (rdata_o !== e) begin
            n_fail++;
            $display("FAIL empty_ready: got %h want %h", rdata_o, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        for (int i = 0; i < DEPTH; i++) tx_write(8'h10 + 8'(i));
        we_i = 1'b1; waddr_i = TX; wdata_i = 8'h18;
        io_ready_i = 1'b1;
        void'(tx_q.pop_front());
        tx_q.push_back(8'h18);
        tick();
        we_i = 1'b0; io_ready_i = 1'b0;
        n_checks++;
        if (ovf_o !== 1'b0 || io_data_o !== tx_q[0]) begin
            n_fail++;
            $display("FAIL full_push_pop: ovf=%b data=%h want 0 %h",
                     ovf_o, io_data_o, tx_q[0]);
        end
        issue_read(STAT, stat_model());
        e = rd_q.pop_front();
        n_checks++;
        if (rdata_o !== e) begin
            n_fail++;
            $display("FAIL full_status: got %h want %h", rdata_o, e);
        end
        tx_write(8'h19);
        n_checks++;
        if (ovf_o !== ovf_m) begin
            n_fail++;
            $display("FAIL full_drop: ovf %b want %b", ovf_o, ovf_m);
        end
        io_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (io_data_o !== tx_q[0]) begin
                n_fail++;
                $display("FAIL part_drain[%0d]: got %h want %h",
                         i, io_data_o, tx_q[0]);
            end
            tick();
            void'(tx_q.pop_front());
        end
        io_ready_i = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [7:0] e;
        n_checks++;
        if (io_valid_o !== 1'b1 || io_data_o !== tx_q[0] || tx_q.size() != 3) begin
            n_fail++;
            $display("FAIL pre_reset: valid=%b data=%h want 1 %h",
                     io_valid_o, io_data_o, tx_q[0]);
        end
        #2;
        rst = 1'b1;
        #1;
        tx_q.delete();
        ovf_m = 1'b0;
        n_checks++;
        if (io_valid_o !== 1'b0 || ovf_o !== 1'b0 ||
            io_data_o !== 8'h00 || rdata_o !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b ovf=%b data=%h rdata=%h",
                     io_valid_o, ovf_o, io_data_o, rdata_o);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        issue_read(32'h10, 8'hA5);
        e = rd_q.pop_front();
        n_checks++;
        if (rdata_o !== e) begin
            n_fail++;
            $display("FAIL ram_kept: got %h want %h", rdata_o, e);
        end
        issue_read(STAT, stat_model());
        e = rd_q.pop_front();
        n_checks++;
        if (rdata_o !== e) begin
            n_fail++;
            $display("FAIL post_reset_status: got %h want %h", rdata_o, e);
        end
    endtask

    initial begin
        #12;
        test_reset();
        test_stream_alias();
        test_write_first();
        test_tx_overflow();
        test_drain();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/byte_ram_responder.md
Name: byte_ram_responder

Overview:
- Responder end of the CPU byte-wide RAM port driven by the memory-access stage: one read channel and one write channel, 8 bits per access.
- Serves a synchronous byte RAM with one-cycle registered read latency.
- Decodes a memory-mapped I/O window: byte writes to the TX address go into a small output FIFO, drained by a valid/ready consumer (UART transmitter); reads of the status address return FIFO flags.

Parameters:
- ADDR_WIDTH, 17, RAM byte-address bits; RAM depth = 2^ADDR_WIDTH bytes.
- IO_TX_ADDR, 32'h00030000, write-only TX byte address.
- IO_STAT_ADDR, 32'h00030004, read-only status byte address.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- re_i  in  1  read enable from the memory-access stage
- raddr_i  in  32  read byte address
- rdata_o  out  8  read data, registered
- we_i  in  1  write enable
- waddr_i  in  32  write byte address
- wdata_i  in  8  write byte
- io_valid_o  out  1  TX FIFO non-empty
- io_data_o  out  8  TX FIFO head byte
- io_ready_i  in  1  consumer accepts head byte this cycle
- ovf_o  out  1  sticky TX overflow flag

Behaviour:
- Reset (async, active-high):
  - rdata_o = 0; FIFO empty; io_valid_o = 0; io_data_o = 0; ovf_o = 0.
  - RAM contents are not cleared.
  - Asserting reset mid-stream discards all queued FIFO bytes.
- Address decode:
  - IO decode compares the full 32-bit address.
  - Any other address is RAM, indexed by addr[ADDR_WIDTH-1:0]; upper bits are ignored (aliasing wrap, no error).
- RAM write: on the edge where we_i=1 and waddr_i is RAM, mem[waddr_i] <= wdata_i.
- RAM read latency:
  - On the edge where re_i=1, rdata_o <= mem[raddr_i].
  - The value is valid from that edge until the next edge with re_i=1.
  - The initiator issues address A at cycle n and samples data at edge n+2, so a new address every cycle streams consecutive bytes.
- re_i=0: rdata_o holds its last value.
- Simultaneous read and write:
  - Both channels are serviced in the same cycle.
  - Same RAM address: write-first; rdata_o gets the new wdata_i.
- Status read (re_i=1, raddr_i=IO_STAT_ADDR): rdata_o <= {5'b0, ovf, full, empty}, sampled before this edge's updates.
  - The same edge clears ovf_o, unless an overflow occurs on that same edge (set wins).
- Reads of IO_TX_ADDR return 8'h00.
- Writes to IO_STAT_ADDR are ignored.
- TX push: on the edge where we_i=1 and waddr_i=IO_TX_ADDR.
  - Accepted if count < FIFO_DEPTH, or if a pop occurs on the same edge.
  - Otherwise the byte is dropped, ovf_o <= 1, and FIFO state is unchanged.
- TX pop: occurs when io_valid_o && io_ready_i.
  - The head advances; io_data_o always shows the current head (first-word-fall-through).
  - io_ready_i with an empty FIFO has no effect.
- Push and pop on the same edge: count unchanged, both pointers advance.
  - When empty, a push is not visible until the next cycle (no bypass).
- FIFO pointers are log2(FIFO_DEPTH)+1 bits, with an extra wrap bit.
  - empty = (wp==rp); full = MSBs differ and the rest are equal.
- io_valid_o = ~empty, registered-state derived, with no combinational path from io_ready_i.
- The block has no stall output; the initiator must never wait on it.

Test Plan:
- Reset, then write 8'hA5 to addr 0x10 and read 0x10 -> rdata_o = 8'hA5 one edge after re_i; io_valid_o stays 0.
- Stream reads 0x20..0x23 on consecutive cycles after writing 11,22,33,44 -> rdata_o shows 11,22,33,44 on consecutive edges; addr 0x20020 (ADDR_WIDTH=17) aliases 0x20.
- Same-cycle write 8'h5A and read at 0x40 (old 8'h00) -> rdata_o = 8'h5A.
- io_ready_i=0, write bytes 1..9 to IO_TX_ADDR -> first 8 queued, 9th dropped; ovf_o=1; status read returns 8'h06; the next status read returns 8'h02.
- Raise io_ready_i -> io_data_o presents 1..8 on successive cycles, then io_valid_o=0; with FIFO full, a push and pop on the same edge keeps full=1 and does not set ovf_o.
- Assert rst with 3 bytes queued mid-drain -> io_valid_o=0 and ovf_o=0 immediately (async); RAM byte at 0x10 still reads 8'hA5.
